addsub_serial: RTL and testbench
================================

// Module: addsub_serial
// PURPOSE
//   Multi-cycle, digit-serial two's-complement adder/subtractor, generalised
//   from the 8-bit ripple add/sub. Computes A+B (mode=0) or A-B (mode=1),
//   DIGIT bits per clock, with a start/busy/done handshake.
//   Reports signed overflow, carry/no-borrow and zero flags.
//   Sits in the datapath wherever a narrow, area-cheap wide-word ALU op is
//   acceptable in exchange for multi-cycle latency.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 2
//   DIGIT  2  bits processed per cycle; 1..WIDTH; WIDTH % DIGIT == 0
//   (N = WIDTH/DIGIT = cycles per op; elaboration error if constraints fail)
// PORTS
//   clk       in   1      rising-edge clock; single clock domain
//   rst       in   1      asynchronous reset, active-high
//   start     in   1      request; sampled when ready (state IDLE or DONE)
//   a         in   WIDTH  operand A; captured on the accepting edge
//   b         in   WIDTH  operand B; captured on the accepting edge
//   mode      in   1      0 = add, 1 = subtract; captured with operands
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse: result/flags just updated
//   result    out  WIDTH  sum/difference modulo 2^WIDTH
//   overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
//   carry     out  1      carry out of MSB (sub: 1 = no borrow)
//   zero      out  1      result == 0
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, busy=0, done=0, result=0,
//     overflow=0, carry=0, zero=0; digit counter and operand regs cleared.
//   - FSM: IDLE -(start)-> RUN; RUN -(last digit)-> DONE; DONE -> IDLE,
//     or DONE -(start)-> RUN (back-to-back accepted, no bubble).
//   - Accept edge: latch a; latch b XOR {WIDTH{mode}}; carry reg = mode;
//     digit count = 0.
//   - RUN: per edge, add digit [DIGIT*k +: DIGIT] of A, ~B/B and carry reg;
//     store the sum digit in the partial-result reg; update carry reg.
//     Capture the carry into bit WIDTH-1 on the last digit for overflow.
//   - Latency: start accepted at edge E0; done=1 in the cycle after edge
//     E0+N. Edge E0+N writes result, overflow, carry and zero together.
//   - Outputs hold the last completed op until the next completion.
//     They are not disturbed during RUN; done deasserts after one cycle.
//   - start while busy: ignored; no queueing; operands not re-sampled.
//   - start held high continuously: a new op starts every N+1 cycles.
//   - Width rule: internal digit add is DIGIT+1 bits; no sign extension.
//     Subtract of most-negative value obeys the same overflow rule.
//   - rst mid-RUN: op aborted, no done pulse, outputs cleared.
//     The first start after release behaves as from cold.
// TESTING  (WIDTH=8, DIGIT=2, N=4 unless noted)
//   add 0x35+0x21 -> result 0x56, ov=0, carry=0, zero=0;
//     done exactly 4 cycles after the accepting edge, 1 cycle wide.
//   add 0x7F+0x01 -> 0x80 ov=1 carry=0; add 0xFF+0x01 -> 0x00 ov=0 carry=1 zero=1.
//   sub 0x80-0x01 -> 0x7F ov=1 carry=1; sub 0x42-0x42 -> 0x00 zero=1 carry=1 ov=0;
//     sub 0x01-0x02 -> 0xFF carry=0.
//   start pulsed mid-RUN with other operands -> ignored, first result intact;
//     start in the DONE cycle -> second op accepted, done again 4 cycles later.
//   rst high 2 cycles into RUN -> all outputs 0 at once, no done pulse;
//     next op after release correct.
//   Sweep DIGIT in {1,2,4,8} and WIDTH=16/DIGIT=4 with 1000 random
//     operand/mode sets vs behavioural model; check N=WIDTH/DIGIT latency.

Source files
------------

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_serial
//  Description : Digit-serial two's-complement adder/subtractor. Computes
//                A+B (mode=0) or A-B (mode=1), DIGIT bits per clock, with a
//                start/busy/done handshake and overflow/carry/zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             zero
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    // Reject illegal parameterisations at elaboration time.
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT (1..WIDTH)");
    end

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Control strobes from the next-state logic
    logic w_accept;     // operands are being latched on this edge
    logic w_last;       // this edge processes the most significant digit

    // Datapath registers: operands are shifted right one digit per edge so
    // the active digit is always in the low DIGIT bits.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtraction
    logic [WIDTH-1:0] r_acc;    // partial result, filled from the top
    logic             r_cy;     // carry between digits
    logic [CNT_W-1:0] r_cnt;    // index of the digit being processed

    // Result/flag registers, written only on completion
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_carry;
    logic             r_zero;

    // Datapath wires
    logic [DIGIT:0]   w_dsum;       // DIGIT-bit sum plus carry-out
    logic             w_cin_msb;    // carry into the top bit of this digit
    logic [WIDTH-1:0] w_acc_next;   // partial result after this digit

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Hold the current FSM state; async reset returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus accept/last-digit strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // start is deliberately ignored here: no queueing.
                if (r_cnt == C_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start seen while done is high is taken immediately,
                // giving back-to-back operation without a bubble.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Digit adder
    // ------------------------------------------------------------------------
    // DIGIT+1 bit add of the current digits and the running carry; the carry
    // into the digit's top bit is recovered from the sum bit so no separate
    // narrower adder is needed for the overflow flag.
    always_comb begin
        w_dsum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_cy};
        w_cin_msb = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    end

    // Shift the new sum digit in at the top of the partial result. After N
    // digits the least significant digit has reached bit 0.
    if (DIGIT < WIDTH) begin : g_acc_shift
        assign w_acc_next = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end else begin : g_acc_whole
        assign w_acc_next = w_dsum[DIGIT-1:0];
    end

    // ------------------------------------------------------------------------
    // Operand, carry and counter registers
    // ------------------------------------------------------------------------
    // Latch operands on accept (B pre-inverted and carry-in = 1 for subtract),
    // then consume one digit per edge while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cy  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b ^ {WIDTH{mode}};
            r_acc <= '0;
            r_cy  <= mode;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_acc <= w_acc_next;
            r_cy  <= w_dsum[DIGIT];
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Result and flags
    // ------------------------------------------------------------------------
    // Update result and all flags together on the last digit; hold otherwise
    // so the visible outputs never show a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_last) begin
            r_result   <= w_acc_next;
            r_overflow <= w_cin_msb ^ w_dsum[DIGIT];
            r_carry    <= w_dsum[DIGIT];
            r_zero     <= (w_acc_next == '0);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign overflow = r_overflow;
    assign carry    = r_carry;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_serial
//  Description : Self-checking bench for addsub_serial: directed cases on the
//                default WIDTH=8/DIGIT=2 build plus a random sweep over
//                several WIDTH/DIGIT builds against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial;

    typedef struct packed {
        logic [15:0] res;
        logic        ov;
        logic        cy;
        logic        z;
        logic [7:0]  lat;
    } exp_t;

    localparam int CW [5] = '{8, 8, 8, 8, 16};
    localparam int CD [5] = '{1, 2, 4, 8, 4};

    logic clk = 1'b0;
    logic rst;

    // Main (directed) instance signals
    logic       d_start, d_mode;
    logic [7:0] d_a, d_b;
    logic       d_busy, d_done, d_ov, d_cy, d_z;
    logic [7:0] d_result;

    // Sweep instance signals
    logic        sw_start, sw_mode;
    logic [15:0] sw_a, sw_b;
    logic        sw_busy [5];
    logic        sw_done [5];
    logic        sw_ov   [5];
    logic        sw_cy   [5];
    logic        sw_z    [5];
    logic [7:0]  sw_res8 [4];
    logic [15:0] sw_res16;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q_main[$];
    exp_t q_sw[$];

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .start(d_start), .a(d_a), .b(d_b), .mode(d_mode),
        .busy(d_busy), .done(d_done), .result(d_result),
        .overflow(d_ov), .carry(d_cy), .zero(d_z)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_s0 (
        .clk(clk), .rst(rst), .start(sw_start), .a(sw_a[7:0]), .b(sw_b[7:0]), .mode(sw_mode),
        .busy(sw_busy[0]), .done(sw_done[0]), .result(sw_res8[0]),
        .overflow(sw_ov[0]), .carry(sw_cy[0]), .zero(sw_z[0])
    );
    addsub_serial #(.WIDTH(8), .DIGIT(2)) u_s1 (
        .clk(clk), .rst(rst), .start(sw_start), .a(sw_a[7:0]), .b(sw_b[7:0]), .mode(sw_mode),
        .busy(sw_busy[1]), .done(sw_done[1]), .result(sw_res8[1]),
        .overflow(sw_ov[1]), .carry(sw_cy[1]), .zero(sw_z[1])
    );
    addsub_serial #(.WIDTH(8), .DIGIT(4)) u_s2 (
        .clk(clk), .rst(rst), .start(sw_start), .a(sw_a[7:0]), .b(sw_b[7:0]), .mode(sw_mode),
        .busy(sw_busy[2]), .done(sw_done[2]), .result(sw_res8[2]),
        .overflow(sw_ov[2]), .carry(sw_cy[2]), .zero(sw_z[2])
    );
    addsub_serial #(.WIDTH(8), .DIGIT(8)) u_s3 (
        .clk(clk), .rst(rst), .start(sw_start), .a(sw_a[7:0]), .b(sw_b[7:0]), .mode(sw_mode),
        .busy(sw_busy[3]), .done(sw_done[3]), .result(sw_res8[3]),
        .overflow(sw_ov[3]), .carry(sw_cy[3]), .zero(sw_z[3])
    );
    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_s4 (
        .clk(clk), .rst(rst), .start(sw_start), .a(sw_a), .b(sw_b), .mode(sw_mode),
        .busy(sw_busy[4]), .done(sw_done[4]), .result(sw_res16),
        .overflow(sw_ov[4]), .carry(sw_cy[4]), .zero(sw_z[4])
    );

    // Behavioural reference: wide add of A, ~B/B and mode; overflow from signs.
    function automatic exp_t model(input logic [15:0] a_v, input logic [15:0] b_v,
                                   input logic m, input int w, input int d);
        exp_t        e;
        logic [15:0] mask, aa, bb, res;
        logic [16:0] full;
        logic        sa, sb, sr;
        mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
        aa    = a_v & mask;
        bb    = (m ? ~b_v : b_v) & mask;
        full  = {1'b0, aa} + {1'b0, bb} + {16'h0, m};
        res   = full[15:0] & mask;
        sa    = aa[w-1];
        sb    = b_v[w-1];
        sr    = res[w-1];
        e.res = res;
        e.cy  = (w == 16) ? full[16] : full[8];
        e.ov  = m ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        e.z   = (res == 16'h0);
        e.lat = 8'(w / d);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Count negedges (starting from c0) until done is seen, bounded.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (d_done !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Pop the oldest expectation and compare it with the main instance.
    task automatic check_main(input string tag);
        exp_t e;
        if (q_main.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = q_main.pop_front();
            chk({tag, "_res"},  d_result, e.res[7:0]);
            chk({tag, "_ov"},   d_ov,     e.ov);
            chk({tag, "_cy"},   d_cy,     e.cy);
            chk({tag, "_z"},    d_z,      e.z);
            chk({tag, "_busy"}, d_busy,   1'b0);
        end
    endtask

    task automatic run_op(input logic [7:0] a_v, input logic [7:0] b_v, input logic m,
                          input string tag);
        int c;
        q_main.push_back(model({8'h0, a_v}, {8'h0, b_v}, m, 8, 2));
        d_a = a_v; d_b = b_v; d_mode = m; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        wait_done(0, c);
        chk({tag, "_lat"}, c, 32'd4);
        check_main(tag);
        @(negedge clk);
        chk({tag, "_done_w"}, d_done, 1'b0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        int          lat   [5];
        int          ndone [5];
        logic [15:0] ra, rb;
        logic        rm;
        exp_t        e;
        logic [15:0] obs;

        rst = 1'b1; d_start = 1'b0; d_a = '0; d_b = '0; d_mode = 1'b0;
        sw_start = 1'b0; sw_a = '0; sw_b = '0; sw_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_res",  d_result, 8'h00);
        chk("rst_ov",   d_ov,     1'b0);
        chk("rst_cy",   d_cy,     1'b0);
        chk("rst_z",    d_z,      1'b0);
        chk("rst_busy", d_busy,   1'b0);
        chk("rst_done", d_done,   1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases
        run_op(8'h35, 8'h21, 1'b0, "add_35_21");
        run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
        run_op(8'h42, 8'h42, 1'b1, "sub_42_42");
        run_op(8'h01, 8'h02, 1'b1, "sub_01_02");
        run_op(8'h00, 8'h80, 1'b1, "sub_00_80");

        // start pulsed mid-RUN with other operands is ignored
        q_main.push_back(model(16'h0010, 16'h0020, 1'b0, 8, 2));
        d_a = 8'h10; d_b = 8'h20; d_mode = 1'b0; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        chk("mid_busy", d_busy, 1'b1);
        @(negedge clk);
        d_a = 8'h99; d_b = 8'h11; d_mode = 1'b1; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        wait_done(2, c);
        chk("mid_lat", c, 32'd4);
        check_main("mid");
        @(negedge clk);

        // Back-to-back: start during the DONE cycle
        q_main.push_back(model(16'h000F, 16'h000F, 1'b0, 8, 2));
        d_a = 8'h0F; d_b = 8'h0F; d_mode = 1'b0; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        wait_done(0, c);
        chk("b2b_x_lat", c, 32'd4);
        check_main("b2b_x");
        q_main.push_back(model(16'h0050, 16'h0020, 1'b1, 8, 2));
        d_a = 8'h50; d_b = 8'h20; d_mode = 1'b1; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        chk("b2b_y_busy", d_busy, 1'b1);
        chk("b2b_hold_res", d_result, 8'h1E);
        wait_done(0, c);
        chk("b2b_y_lat", c, 32'd4);
        check_main("b2b_y");
        @(negedge clk);

        // start held high: one op every N+1 cycles
        q_main.push_back(model(16'h00C0, 16'h0050, 1'b0, 8, 2));
        q_main.push_back(model(16'h00C0, 16'h0050, 1'b0, 8, 2));
        d_a = 8'hC0; d_b = 8'h50; d_mode = 1'b0; d_start = 1'b1;
        @(negedge clk);
        wait_done(0, c);
        chk("cont1_lat", c, 32'd4);
        check_main("cont1");
        @(negedge clk);
        wait_done(1, c);
        chk("cont_period", c, 32'd5);
        check_main("cont2");
        d_start = 1'b0;
        @(negedge clk);

        // Reset two cycles into RUN: outputs clear at once, no done pulse
        d_a = 8'h05; d_b = 8'h06; d_mode = 1'b0; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_res",  d_result, 8'h00);
        chk("abort_ov",   d_ov,     1'b0);
        chk("abort_cy",   d_cy,     1'b0);
        chk("abort_z",    d_z,      1'b0);
        chk("abort_busy", d_busy,   1'b0);
        chk("abort_done", d_done,   1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_nodone", d_done, 1'b0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_nodone_after", d_done, 1'b0);
        end
        run_op(8'h12, 8'h34, 1'b0, "post_rst");

        // Random sweep across WIDTH/DIGIT builds
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            if (i % 16 == 0) ra = 16'h8000;
            if (i % 16 == 8) ra = 16'h0080;
            if (i % 32 == 4) rb = ra;
            for (int j = 0; j < 5; j++) begin
                q_sw.push_back(model(ra, rb, rm, CW[j], CD[j]));
                lat[j]   = -1;
                ndone[j] = 0;
            end
            sw_a = ra; sw_b = rb; sw_mode = rm; sw_start = 1'b1;
            @(negedge clk);
            sw_start = 1'b0;
            for (int cc = 0; cc < 12; cc++) begin
                if (cc > 0) @(negedge clk);
                for (int j = 0; j < 5; j++) begin
                    if (sw_done[j] === 1'b1) begin
                        ndone[j]++;
                        if (lat[j] < 0) lat[j] = cc;
                    end
                end
            end
            for (int j = 0; j < 5; j++) begin
                e   = q_sw.pop_front();
                obs = (j < 4) ? {8'h00, sw_res8[j]} : sw_res16;
                chk($sformatf("sw%0d_lat", j),   lat[j],     {24'h0, e.lat});
                chk($sformatf("sw%0d_ndone", j), ndone[j],   32'd1);
                chk($sformatf("sw%0d_res", j),   obs,        {16'h0, e.res});
                chk($sformatf("sw%0d_ov", j),    sw_ov[j],   e.ov);
                chk($sformatf("sw%0d_cy", j),    sw_cy[j],   e.cy);
                chk($sformatf("sw%0d_z", j),     sw_z[j],    e.z);
                chk($sformatf("sw%0d_busy", j),  sw_busy[j], 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
